// File: rtl/pc_seq.sv
// Program-counter sequencer: alternates FETCH/EXEC, picks the next pc per instruction class,
// and stops in HALT or FAULT on halt instructions or return-stack overflow/underflow.
module pc_seq #(
    parameter int              AW       = 12,
    parameter int              DEPTH    = 4,
    parameter logic [AW-1:0]   RESET_PC = 12'h000
) (
    input  logic          ck,
    input  logic          res,
    input  logic          stall,
    input  logic [3:0]    kind,
    input  logic [AW-1:0] target,
    input  logic          zf,
    input  logic [AW-1:0] stack_d,
    input  logic [2:0]    sp,
    output logic          ck2,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] one_addr,
    output logic          halted,
    output logic [1:0]    fault
);

    localparam logic [2:0] DEPTH_SP = 3'(DEPTH);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_nxt;
    logic [AW-1:0] w_pc_inc;
    logic [1:0]    r_fault;
    logic [1:0]    w_fault_nxt;
    logic          r_ck2;
    logic          r_halted;

    // Natural AW-bit wrap gives the all-ones -> 0 rollover with no carry out.
    assign w_pc_inc = r_pc + AW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_fault_nxt = r_fault;
        case (r_state)
            ST_FETCH: begin
                if (!stall) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_FETCH;
                w_pc_nxt    = w_pc_inc;
                case (kind)
                    4'b0100: begin
                        if (zf) begin
                            w_pc_nxt = target;
                        end
                    end
                    4'b0101: w_pc_nxt = target;
                    4'b0110: begin
                        if (sp < DEPTH_SP) begin
                            w_pc_nxt = target;
                        end else begin
                            w_pc_nxt    = r_pc;
                            w_state_nxt = ST_FAULT;
                            w_fault_nxt = 2'b01;
                        end
                    end
                    4'b0111: begin
                        if (sp != 3'd0) begin
                            w_pc_nxt = stack_d;
                        end else begin
                            w_pc_nxt    = r_pc;
                            w_state_nxt = ST_FAULT;
                            w_fault_nxt = 2'b10;
                        end
                    end
                    4'b1111: begin
                        w_pc_nxt    = r_pc;
                        w_state_nxt = ST_HALT;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // ck2 and halted are registered from the next state so they change with the state, glitch-free.
    always_ff @(posedge ck or posedge res) begin
        if (res) begin
            r_state  <= ST_FETCH;
            r_pc     <= RESET_PC;
            r_fault  <= 2'b00;
            r_ck2    <= 1'b1;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_fault  <= w_fault_nxt;
            r_ck2    <= (w_state_nxt != ST_EXEC);
            r_halted <= (w_state_nxt == ST_HALT) || (w_state_nxt == ST_FAULT);
        end
    end

    assign ck2      = r_ck2;
    assign pc       = r_pc;
    assign one_addr = w_pc_inc;
    assign halted   = r_halted;
    assign fault    = r_fault;

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboarded bench for pc_seq: a tiny return stack device, a queue-based reference model,
// and a monitor that checks pc/one_addr whenever the sequencer shows an EXEC phase.
module tb_pc_seq;

    logic        ck = 1'b0;
    logic        res = 1'b0;
    logic        stall = 1'b1;
    logic [3:0]  kind = 4'd0;
    logic [11:0] target = 12'd0;
    logic        zf = 1'b0;
    logic [11:0] stack_d;
    logic [2:0]  sp;
    logic        ck2;
    logic [11:0] pc;
    logic [11:0] one_addr;
    logic        halted;
    logic [1:0]  fault;

    pc_seq #(.AW(12), .DEPTH(4), .RESET_PC(12'h000)) dut (
        .ck(ck), .res(res), .stall(stall), .kind(kind), .target(target), .zf(zf),
        .stack_d(stack_d), .sp(sp), .ck2(ck2), .pc(pc), .one_addr(one_addr),
        .halted(halted), .fault(fault)
    );

    always #5 ck = ~ck;

    // Return-address stack device driven by the sequencer.
    logic [11:0] env_stk [8];
    logic [3:0]  env_sp;
    assign sp      = env_sp[2:0];
    assign stack_d = (env_sp != 4'd0) ? env_stk[env_sp[2:0] - 3'd1] : 12'h000;

    always @(posedge ck or posedge res) begin
        if (res) begin
            env_sp <= 4'd0;
        end else if (!ck2) begin
            if (kind == 4'b0110 && env_sp < 4'd4) begin
                env_stk[env_sp[2:0]] <= one_addr;
                env_sp <= env_sp + 4'd1;
            end else if (kind == 4'b0111 && env_sp != 4'd0) begin
                env_sp <= env_sp - 4'd1;
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pc as an integer, call stack as a queue.
    int     m_pc;
    int     m_stk[$];
    bit     m_halt;
    int     m_fault;
    int     exp_q[$];

    task automatic model_step(input int k, input int t, input bit z);
        int inc;
        inc = (m_pc + 1) % 4096;
        case (k)
            4: m_pc = z ? t : inc;
            5: m_pc = t;
            6: if (m_stk.size() < 4) begin m_stk.push_back(inc); m_pc = t; end
               else begin m_halt = 1; m_fault = 1; end
            7: if (m_stk.size() > 0) m_pc = m_stk.pop_back();
               else begin m_halt = 1; m_fault = 2; end
            15: m_halt = 1;
            default: m_pc = inc;
        endcase
    endtask

    // Monitor: every EXEC phase must correspond to an issued instruction.
    bit prev_exec = 0;
    always @(negedge ck) begin
        if (res) begin
            prev_exec = 0;
        end else if (!ck2) begin
            chk("ck2_low_twice", int'(prev_exec), 0);
            chk("halted_in_exec", int'(halted), 0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_exec: got EXEC at pc=%0h, required no EXEC", pc);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("exec_pc", int'(pc), e);
                chk("one_addr", int'(one_addr), (e + 1) % 4096);
            end
            prev_exec = 1;
        end else begin
            prev_exec = 0;
        end
    end

    task automatic do_reset();
        res = 1'b1;
        exp_q.delete();
        m_stk.delete();
        m_pc = 0;
        m_halt = 0;
        m_fault = 0;
        #1;
        chk("rst_pc", int'(pc), 0);
        chk("rst_ck2", int'(ck2), 1);
        chk("rst_halted", int'(halted), 0);
        chk("rst_fault", int'(fault), 0);
        @(negedge ck);
        res = 1'b0;
        stall = 1'b1;
    endtask

    // Called at a negedge; returns at a negedge with the sequencer in FETCH/HALT/FAULT.
    task automatic do_instr(input int k, input int t, input bit z, input int nst);
        for (int i = 0; i < nst; i++) begin
            stall = 1'b1;
            @(negedge ck);
            chk("stall_ck2", int'(ck2), 1);
            chk("stall_pc", int'(pc), m_pc);
        end
        stall  = 1'b0;
        kind   = 4'(k);
        target = 12'(t);
        zf     = z;
        if (!m_halt) exp_q.push_back(m_pc);
        @(negedge ck);
        if (!m_halt) model_step(k, t, z);
        @(negedge ck);
        stall = 1'b1;
        kind  = 4'd0;
        chk("pc", int'(pc), m_pc);
        chk("halted", int'(halted), int'(m_halt));
        chk("fault", int'(fault), m_fault);
    endtask

    initial begin
        @(negedge ck);
        do_reset();

        // Sequential run and ck2 alternation
        for (int i = 0; i < 3; i++) do_instr(0, 0, 0, 0);
        chk("seq_pc3", int'(pc), 3);

        // Call and return
        do_instr(5, 12'h010, 0, 0);
        do_instr(6, 12'h200, 0, 0);
        chk("jsb_pc", int'(pc), 12'h200);
        chk("stack_top", int'(stack_d), 12'h011);
        do_instr(7, 0, 0, 0);
        chk("ret_pc", int'(pc), 12'h011);

        // Wraparound
        do_instr(5, 12'hFFF, 0, 0);
        chk("one_addr_wrap", int'(one_addr), 0);
        do_instr(0, 0, 0, 0);
        chk("wrap_pc", int'(pc), 0);

        // Conditional branch with stalls
        do_instr(4, 12'h080, 0, 5);
        chk("bz_nt", int'(pc), 1);
        do_instr(4, 12'h080, 1, 5);
        chk("bz_t", int'(pc), 12'h080);

        // Overflow on the fifth nested call
        for (int i = 0; i < 4; i++) do_instr(6, 12'h100 + i * 16, 0, i % 2);
        do_instr(6, 12'h555, 0, 0);
        chk("ovf_fault", int'(fault), 1);
        for (int i = 0; i < 12; i++) begin
            stall = 1'($urandom_range(0, 1));
            kind  = 4'($urandom_range(0, 15));
            @(negedge ck);
            chk("ovf_hold_ck2", int'(ck2), 1);
            chk("ovf_hold_pc", int'(pc), m_pc);
            chk("ovf_hold_halted", int'(halted), 1);
        end
        stall = 1'b1;

        // Underflow
        do_reset();
        do_instr(7, 0, 0, 0);
        chk("unf_fault", int'(fault), 2);
        do_instr(0, 0, 0, 1);

        // Randomized instruction mix
        do_reset();
        for (int n = 0; n < 300; n++) begin
            int k;
            k = $urandom_range(0, 15);
            if (k == 15 && $urandom_range(0, 7) != 0) k = 0;
            if (k > 7 && k != 15) k = $urandom_range(4, 7);
            do_instr(k, $urandom_range(0, 4095), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
            if (m_halt) do_reset();
        end

        // Async reset during EXEC
        do_instr(5, 12'h3A0, 0, 0);
        stall  = 1'b0;
        kind   = 4'b0101;
        target = 12'h123;
        exp_q.push_back(m_pc);
        @(negedge ck);
        #2 res = 1'b1;
        #1;
        chk("areset_ck2", int'(ck2), 1);
        chk("areset_pc", int'(pc), 0);
        @(negedge ck);
        chk("areset_hold_pc", int'(pc), 0);
        stall = 1'b1;
        res = 1'b0;
        m_pc = 0;
        m_stk.delete();
        m_halt = 0;
        m_fault = 0;
        @(negedge ck);
        chk("areset_after_pc", int'(pc), 0);

        chk("unconsumed_exec", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
